// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: conditions raw slide-switch pins into clean, clk-synchronous
// levels for the switch PIO. Each bit passes through a 2-flop synchronizer and
// then a counter-based debounce. A one-cycle change strobe plus a mask of the
// bits that updated are registered alongside sw_stable for an edge-capture/IRQ
// stage.
//
// Build option: define SW_DEBOUNCE_BYPASS_EN to drop the counters. The
// synchronized level is then accepted on every edge, which is useful to speed
// up simulation. The strobe outputs keep the same timing relation.
module sw_debounce_sync #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed_pulse,
  output logic [WIDTH-1:0] changed_mask
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] upd;

  // Two-flop synchronizer; nothing sits between the stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  // Bypass: any disagreement between s2 and sw_stable is accepted at once
  assign upd = s2 ^ sw_stable;
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // A bit updates once it has disagreed with sw_stable for the full count
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (s2[i] != sw_stable[i]) && (cnt[i] == LAST);
    end
  end

  // Per-bit counters: any agreement clears, so there is no partial credit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

  // Accepted level and the change strobes, all registered on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable     <= '0;
      changed_mask  <= '0;
      changed_pulse <= 1'b0;
    end else begin
      sw_stable     <= sw_stable ^ upd;
      changed_mask  <= upd;
      changed_pulse <= |upd;
    end
  end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Testbench for sw_debounce_sync with DEBOUNCE_CYCLES=4. The reference model
// keeps a history of the raw values sampled at each edge. A bit is accepted
// when the synchronized samples in the last window have all differed from the
// model's stable level.
module tb_sw_debounce_sync;
  localparam int WIDTH = 16;
  localparam int D     = 4;
  localparam int CW    = 3;
`ifdef SW_DEBOUNCE_BYPASS_EN
  localparam int MD = 1;
`else
  localparam int MD = D;
`endif
  localparam int LAT = 2 + MD;  // step index of update when step 1 samples the change

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_stable;
  logic             changed_pulse;
  logic [WIDTH-1:0] changed_mask;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] m_stable;
  logic [WIDTH-1:0] m_mask;
  logic             m_pulse;
  logic [WIDTH-1:0] hist [0:MD];  // hist[k] = raw sampled k+1 edges before current edge

  sw_debounce_sync #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .changed_pulse(changed_pulse), .changed_mask(changed_mask)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_stable = '0;
    m_mask   = '0;
    m_pulse  = 1'b0;
    for (int k = 0; k <= MD; k++) hist[k] = '0;
  endtask

  // Advance one edge, update the model, then settle 1 time unit past the edge
  task automatic step();
    logic [WIDTH-1:0] u;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      u = '0;
      for (int i = 0; i < WIDTH; i++) begin
        u[i] = 1'b1;
        for (int k = 1; k <= MD; k++) if (hist[k][i] == m_stable[i]) u[i] = 1'b0;
      end
      m_stable = m_stable ^ u;
      m_mask   = u;
      m_pulse  = |u;
      for (int k = MD; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw_raw;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sw_raw  = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int first, pulses;
    logic [WIDTH-1:0] pmask;
    reset_n = 1'b0;
    sw_raw  = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (sw_stable !== '0 || changed_pulse !== 1'b0 || changed_mask !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got stable=%h pulse=%b mask=%h want 0/0/0",
                 c, sw_stable, changed_pulse, changed_mask);
      end
    end
    reset_n = 1'b1;
    first = 0; pulses = 0; pmask = '0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL reset_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse) begin pulses++; pmask = changed_mask; end
      if (first == 0 && sw_stable == 16'hFFFF) first = e;
    end
    checks++;
    if (first != LAT) begin errors++; $display("FAIL reset_latency got=%0d want=%0d", first, LAT); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL reset_pulses got=%0d want=1", pulses); end
    checks++;
    if (pmask !== 16'hFFFF) begin errors++; $display("FAIL reset_mask got=%h want=ffff", pmask); end
  endtask

  task automatic test_clean_edge();
    int first, pulses;
    logic [WIDTH-1:0] pmask;
    do_reset();
    sw_raw[0] = 1'b1;
    first = 0; pulses = 0; pmask = '0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL clean_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse) begin pulses++; pmask = changed_mask; end
      if (first == 0 && sw_stable[0]) first = e;
    end
    checks++;
    if (first != LAT) begin errors++; $display("FAIL clean_latency got=%0d want=%0d", first, LAT); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL clean_pulses got=%0d want=1", pulses); end
    checks++;
    if (pmask !== 16'h0001) begin errors++; $display("FAIL clean_mask got=%h want=0001", pmask); end
  endtask

  task automatic test_glitch();
    int pulses, last_rise, want_pulses;
    want_pulses = (MD > 3) ? 0 : 2;
    do_reset();
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      sw_raw[3] = (e <= 3);
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL glitch_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse) pulses++;
    end
    checks++;
    if (pulses != want_pulses) begin
      errors++; $display("FAIL glitch_pulses got=%0d want=%0d", pulses, want_pulses);
    end
    last_rise = 0;
    for (int e = 1; e <= 12; e++) begin
      sw_raw[3] = (e != 2);
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL bounce_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse && changed_mask[3] && sw_stable[3]) last_rise = e;
    end
    checks++;
    if (last_rise != 4 + MD) begin
      errors++; $display("FAIL bounce_latency got=%0d want=%0d", last_rise, 4 + MD);
    end
  endtask

  task automatic test_simultaneous();
    int pulses, e1, e2;
    logic [WIDTH-1:0] pm1, pm2;
    do_reset();
    sw_raw = 16'h8001;
    pulses = 0; pm1 = '0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL simul_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse) begin pulses++; pm1 = changed_mask; end
    end
    checks++;
    if (pulses != 1 || pm1 !== 16'h8001) begin
      errors++; $display("FAIL simul_pulse got pulses=%0d mask=%h want 1/8001", pulses, pm1);
    end
    do_reset();
    e1 = 0; e2 = 0; pm1 = '0; pm2 = '0;
    sw_raw[4] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      sw_raw[5] = 1'b1;
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL b2b_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (changed_pulse) begin
        if (e1 == 0) begin e1 = e; pm1 = changed_mask; end
        else if (e2 == 0) begin e2 = e; pm2 = changed_mask; end
      end
    end
    checks++;
    if (e1 != LAT || e2 != LAT + 1 || pm1 !== 16'h0010 || pm2 !== 16'h0020) begin
      errors++;
      $display("FAIL b2b_pulses got e1=%0d m1=%h e2=%0d m2=%h want %0d/0010 %0d/0020",
               e1, pm1, e2, pm2, LAT, LAT + 1);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    do_reset();
    sw_raw[2] = 1'b1;
    for (int e = 1; e <= 5; e++) step();
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (sw_stable !== '0 || changed_pulse !== 1'b0 || changed_mask !== '0) begin
      errors++;
      $display("FAIL midreset_async got %h/%b/%h want 0/0/0", sw_stable, changed_pulse, changed_mask);
    end
    step();
    step();
    reset_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        $display("FAIL midreset_model e=%0d got %h/%b/%h want %h/%b/%h", e,
                 sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
      if (first == 0 && sw_stable[2]) first = e;
    end
    checks++;
    if (first != LAT) begin errors++; $display("FAIL midreset_latency got=%0d want=%0d", first, LAT); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < WIDTH; i++) if ($urandom_range(0, 5) == 0) sw_raw[i] = ~sw_raw[i];
      reset_n = ($urandom_range(0, 149) != 0);
      step();
      checks++;
      if (sw_stable !== m_stable || changed_pulse !== m_pulse || changed_mask !== m_mask) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_model c=%0d got %h/%b/%h want %h/%b/%h", c,
                   sw_stable, changed_pulse, changed_mask, m_stable, m_pulse, m_mask);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_edge();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
- Conditions raw slide-switch inputs from the board pins into clean, clk-synchronous levels.
- Output sw_stable drives the in_port of the 16-bit switch PIO read by the Nios II.
- Per bit, in order: 2-flop synchronizer, then counter-based debounce.
- Also emits a one-cycle change strobe and a mask of the bits that changed, for a downstream edge-capture/IRQ stage.

Parameters:
- WIDTH, 16, number of switch bits.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized bit must differ from sw_stable before it is accepted (10 ms at 50 MHz). Must be >= 1.
- CNT_W, 20, width of each per-bit counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sw_raw  in  WIDTH  asynchronous switch pins; may bounce.
- sw_stable  out  WIDTH  debounced level; feeds PIO in_port.
- changed_pulse  out  1  high for one cycle when any sw_stable bit updates.
- changed_mask  out  WIDTH  bits that updated at that edge; valid while changed_pulse = 1, else 0.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is on posedge clk / negedge reset_n.
- Reset values:
  - sync stage 1 and stage 2: all 0.
  - counters: 0.
  - sw_stable: 0.
  - changed_pulse: 0.
  - changed_mask: 0.
- Synchronizer: s1 <= sw_raw; s2 <= s1. No logic between s1 and s2.
- Per-bit debounce, bit i, each edge:
  - If s2[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: if sw_raw[i] holds a new value from the setup of edge N onward, sw_stable[i] updates at edge N+1+DEBOUNCE_CYCLES. Exactly this value, not within +-1.
- Glitch rejection: any return of s2[i] to the sw_stable[i] value before the count completes clears cnt[i]. The next attempt restarts at 0; there is no partial credit.
- Counters never wrap. The maximum count reached is DEBOUNCE_CYCLES-1.
- Strobe outputs are registered at the same edge as the sw_stable update:
  - changed_mask[i] <= 1 if bit i updates at this edge, else 0.
  - changed_pulse <= OR of the new changed_mask.
- Simultaneous updates of several bits produce one pulse with all of those bits set in the mask.
- Updates on consecutive edges produce back-to-back pulses, each with its own mask.
- Bits are fully independent; one bit's bouncing never affects another bit's counter.
- Reset asserted mid-count clears all state immediately (asynchronously). After release, a changed input needs the full N+1+DEBOUNCE_CYCLES again.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SW_DEBOUNCE_BYPASS_EN, used to speed up simulation.
- Defined:
  - Counters are not instantiated.
  - sw_stable[i] <= s2[i] every edge, so latency is edge N+2.
  - changed_pulse/changed_mask are still generated from sw_stable transitions with the same timing relation as above.
- Undefined: full debounce behaviour as specified above.

Test Plan:
1. Reset: hold reset_n=0 with sw_raw=16'hFFFF for 10 cycles. sw_stable=0, changed_pulse=0 and changed_mask=0 throughout. After release with DEBOUNCE_CYCLES=4, sw_stable=16'hFFFF at exactly edge 6 after release, plus one pulse with mask 16'hFFFF.
2. Clean edge (DEBOUNCE_CYCLES=4): sw_raw[0] 0->1, sampled at edge N. sw_stable[0]=1 at edge N+5 and not earlier. changed_pulse high for exactly one cycle, with changed_mask=16'h0001.
3. Glitch: sw_raw[3] high for 3 cycles, then low. sw_stable stays 16'h0000 and no pulse occurs. Then bounce 1-0-1 and hold: the update lands 5 edges after the last 0->1 sample.
4. Simultaneous bits: sw_raw 16'h0000->16'h8001 on one edge gives a single pulse with mask 16'h8001. Bits 4 and 5 changed one cycle apart give two consecutive pulses with masks 16'h0010 then 16'h0020.
5. Reset mid-operation: sw_raw[2]=1 held; assert reset_n=0 after 3 counting cycles for 2 cycles. sw_stable[2] stays 0 and the count restarts after release, so the update comes at edge 6 after release, not earlier.
6. With SW_DEBOUNCE_BYPASS_EN defined: sw_raw=16'h00A5 sampled at edge N gives sw_stable=16'h00A5 at edge N+2, with a one-cycle pulse and mask 16'h00A5.
